// File: rtl/rst_pulse_gen_pkg.sv
// rtl/rst_pulse_gen_pkg.sv - shared timing defaults, cause codes and FSM encoding for rst_pulse_gen
package rst_pulse_gen_pkg;

`ifdef SIM
    localparam logic [31:0] DEF_PULSE_TIME = 32'd16;
    localparam logic [31:0] DEF_HOLDOFF    = 32'd8;
    localparam logic [31:0] DEF_DEB_TIME   = 32'd4;
    localparam logic [31:0] DEF_WDT_TIME   = 32'd64;
`else
    localparam logic [31:0] DEF_PULSE_TIME = 32'd50000;
    localparam logic [31:0] DEF_HOLDOFF    = 32'd50000;
    localparam logic [31:0] DEF_DEB_TIME   = 32'd1000000;
    localparam logic [31:0] DEF_WDT_TIME   = 32'd50000000;
`endif

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_KEY  = 2'b01;
    localparam logic [1:0] CAUSE_SOFT = 2'b10;
    localparam logic [1:0] CAUSE_WDT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ASSERT  = 2'b01,
        ST_HOLDOFF = 2'b10
    } state_t;

endpackage

// File: rtl/rst_pulse_gen_key_debounce.sv
// rtl/rst_pulse_gen_key_debounce.sv - push-button synchroniser and debounce, one key_evt per press
module key_debounce
    import rst_pulse_gen_pkg::*;
#(
    parameter logic [31:0] DEB_TIME = DEF_DEB_TIME
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_evt
);

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic [31:0] cnt_q, cnt_d;

    // Count parks one past the trigger value so a held key fires only once.
    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        if (sync2_q) begin
            cnt_d = 32'd0;
        end else if (cnt_q != DEB_TIME) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    assign key_evt = !sync2_q && (cnt_q == DEB_TIME - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= 32'd0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/rst_pulse_gen.sv
// rtl/rst_pulse_gen.sv - merges key, software and watchdog requests into one stretched active-low reset pulse
module rst_pulse_gen
    import rst_pulse_gen_pkg::*;
#(
    parameter logic [31:0] PULSE_TIME = DEF_PULSE_TIME,
    parameter logic [31:0] HOLDOFF    = DEF_HOLDOFF,
    parameter logic [31:0] DEB_TIME   = DEF_DEB_TIME,
    parameter logic [31:0] WDT_TIME   = DEF_WDT_TIME
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_n,
    input  logic       soft_req,
    input  logic       wdt_en,
    input  logic       wdt_kick,
    output logic       rst_req_n,
    output logic       busy,
    output logic [1:0] rst_cause
);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] wdt_cnt_q, wdt_cnt_d;
    logic        rst_req_n_q, rst_req_n_d;
    logic        busy_q, busy_d;
    logic [1:0]  cause_q, cause_d;
    logic        key_evt;
    logic        wdt_run;
    logic        wdt_evt;
    logic        any_evt;
    logic [1:0]  winner;

    key_debounce #(
        .DEB_TIME (DEB_TIME)
    ) u_key_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n   (key_n),
        .key_evt (key_evt)
    );

    // Watchdog freezes while a pulse is in flight; a kick beats a coincident timeout.
    always_comb begin
        wdt_run   = wdt_en && (state_q == ST_IDLE);
        wdt_evt   = wdt_run && !wdt_kick && (wdt_cnt_q == WDT_TIME - 32'd1);
        wdt_cnt_d = wdt_cnt_q;
        if (!wdt_en || wdt_kick || wdt_evt) begin
            wdt_cnt_d = 32'd0;
        end else if (wdt_run) begin
            wdt_cnt_d = wdt_cnt_q + 32'd1;
        end
    end

    always_comb begin
        any_evt = wdt_evt || soft_req || key_evt;
        if (wdt_evt) begin
            winner = CAUSE_WDT;
        end else if (soft_req) begin
            winner = CAUSE_SOFT;
        end else begin
            winner = CAUSE_KEY;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (any_evt) begin
                    state_d = ST_ASSERT;
                    cnt_d   = 32'd0;
                end
            end
            ST_ASSERT: begin
                if (cnt_q == PULSE_TIME - 32'd1) begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == HOLDOFF - 32'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 32'd0;
            end
        endcase
    end

    // Outputs are registered alongside the state so they change on the same edge.
    always_comb begin
        rst_req_n_d = (state_d != ST_ASSERT);
        busy_d      = (state_d != ST_IDLE);
        cause_d     = cause_q;
        if ((state_q == ST_IDLE) && any_evt) begin
            cause_d = winner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 32'd0;
            wdt_cnt_q   <= 32'd0;
            rst_req_n_q <= 1'b1;
            busy_q      <= 1'b0;
            cause_q     <= CAUSE_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wdt_cnt_q   <= wdt_cnt_d;
            rst_req_n_q <= rst_req_n_d;
            busy_q      <= busy_d;
            cause_q     <= cause_d;
        end
    end

    assign rst_req_n = rst_req_n_q;
    assign busy      = busy_q;
    assign rst_cause = cause_q;

endmodule

// File: tb/tb_rst_pulse_gen.sv
// tb/tb_rst_pulse_gen.sv - directed self-checking bench for rst_pulse_gen at short timing values
module tb_rst_pulse_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_n;
    logic       soft_req;
    logic       wdt_en;
    logic       wdt_kick;
    logic       rst_req_n;
    logic       busy;
    logic [1:0] rst_cause;

    int n_vec = 0;
    int n_bad = 0;
    int pulse_cnt = 0;

    rst_pulse_gen #(
        .PULSE_TIME (32'd16),
        .HOLDOFF    (32'd8),
        .DEB_TIME   (32'd4),
        .WDT_TIME   (32'd64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_n     (key_n),
        .soft_req  (soft_req),
        .wdt_en    (wdt_en),
        .wdt_kick  (wdt_kick),
        .rst_req_n (rst_req_n),
        .busy      (busy),
        .rst_cause (rst_cause)
    );

    always #5 clk = ~clk;

    always @(negedge rst_req_n) begin
        if (rst_n) pulse_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Returns the number of rising edges until rst_req_n is seen low (bounded).
    task automatic wait_low(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            if (!rst_req_n) break;
        end
    endtask

    task automatic soft_pulse();
        soft_req = 1'b1;
        step(1);
        soft_req = 1'b0;
    endtask

    int p0;
    int lows;
    int busys;
    int el;

    initial begin
        rst_n = 1'b0; key_n = 1'b1; soft_req = 1'b0; wdt_en = 1'b0; wdt_kick = 1'b0;
        step(3);
        chk("reset_rst_req_n", rst_req_n, 1);
        chk("reset_busy", busy, 0);
        chk("reset_cause", rst_cause, 0);
        rst_n = 1'b1;
        step(3);

        // 1: software request
        soft_pulse();
        chk("soft_first_low", rst_req_n, 0);
        lows = 0; busys = 0;
        for (int i = 0; i < 40; i++) begin
            if (!rst_req_n) lows++;
            if (busy) busys++;
            step(1);
        end
        chk("soft_low_cycles", lows, 16);
        chk("soft_busy_cycles", busys, 24);
        chk("soft_cause", rst_cause, 2);

        // 2: key debounce
        p0 = pulse_cnt;
        key_n = 1'b0; step(3); key_n = 1'b1; step(20);
        chk("key_short_no_pulse", pulse_cnt - p0, 0);
        key_n = 1'b0; step(10); key_n = 1'b1; step(40);
        chk("key_press_one_pulse", pulse_cnt - p0, 1);
        chk("key_cause", rst_cause, 1);
        p0 = pulse_cnt;
        key_n = 1'b0; step(200); key_n = 1'b1; step(40);
        chk("key_held_one_pulse", pulse_cnt - p0, 1);

        // 3: watchdog kicked then starved
        p0 = pulse_cnt;
        wdt_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(49);
            wdt_kick = 1'b1; step(1); wdt_kick = 1'b0;
        end
        chk("wdt_kicked_no_pulse", pulse_cnt - p0, 0);
        wdt_kick = 1'b1; step(1); wdt_kick = 1'b0;
        wait_low(el);
        chk("wdt_timeout_edges", el, 64);
        chk("wdt_cause", rst_cause, 3);
        wdt_en = 1'b0;
        step(30);

        // 4: soft and watchdog coincide, then soft during holdoff
        p0 = pulse_cnt;
        wdt_en = 1'b1;
        wdt_kick = 1'b1; step(1); wdt_kick = 1'b0;
        step(63);
        soft_pulse();
        chk("coincide_low", rst_req_n, 0);
        chk("coincide_cause", rst_cause, 3);
        wdt_en = 1'b0;
        step(18);
        chk("holdoff_busy", busy, 1);
        chk("holdoff_rst_req_n", rst_req_n, 1);
        soft_pulse();
        step(40);
        chk("holdoff_soft_ignored", pulse_cnt - p0, 1);
        chk("holdoff_cause_kept", rst_cause, 3);

        // 5: reset mid-pulse
        soft_pulse();
        step(5);
        chk("midpulse_low_before", rst_req_n, 0);
        rst_n = 1'b0;
        #1;
        chk("midpulse_rst_req_n", rst_req_n, 1);
        chk("midpulse_busy", busy, 0);
        chk("midpulse_cause", rst_cause, 0);
        step(2);
        rst_n = 1'b1;
        p0 = pulse_cnt;
        step(40);
        chk("after_reset_no_pulse", pulse_cnt - p0, 0);
        chk("after_reset_idle", busy, 0);

        // 6: watchdog disable restarts the timeout
        p0 = pulse_cnt;
        wdt_en = 1'b1; step(30);
        wdt_en = 1'b0; step(5);
        chk("wdt_toggle_no_pulse", pulse_cnt - p0, 0);
        wdt_en = 1'b1;
        wait_low(el);
        chk("wdt_reenable_edges", el, 64);
        chk("wdt_reenable_cause", rst_cause, 3);
        wdt_en = 1'b0;
        step(30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
